// File: rtl/hamming_2d_pkg.sv
// rtl/hamming_2d_pkg.sv - shared constants, types and helpers for the 2D Hamming path
package hamming_2d_pkg;

  localparam int DATA_W     = 44;
  localparam int ROW_DATA_W = 11;
  localparam int ROW_CW_W   = 15;
  localparam int ROWS       = 4;
  localparam int COLS       = 15;
  localparam int COL_CW_W   = 7;
  localparam int CW_W       = 105;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Number of lane beats needed to carry one full codeword.
  function automatic int beats_for(input int lane_w);
    return (CW_W + lane_w - 1) / lane_w;
  endfunction

endpackage

// File: rtl/hamming_cw_hold_reg.sv
// rtl/hamming_cw_hold_reg.sv - single-entry codeword holding slot with full flag
module hamming_cw_hold_reg
  import hamming_2d_pkg::*;
#(
  parameter int W = CW_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         take_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // Take empties the slot; a load in the same cycle refills it with the new word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take_i) begin
      full_d = 1'b0;
    end
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  // Slot storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/hamming_2d_serializer.sv
// rtl/hamming_2d_serializer.sv - streams 105-bit codewords out LSB-first as LANE_W-bit beats
module hamming_2d_serializer
  import hamming_2d_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cw_valid,
  output logic              cw_ready,
  input  logic [CW_W-1:0]   cw_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic [7:0]        out_vbits,
  output logic              busy
);

  localparam int BEATS     = beats_for(LANE_W);
  localparam int LAST_BITS = CW_W - (BEATS - 1) * LANE_W;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [7:0]       VB_LANE  = 8'(LANE_W);
  localparam logic [7:0]       VB_LAST  = 8'(LAST_BITS);

  ser_state_e        state_q, state_d;
  logic [CW_W-1:0]   act_q, act_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pend_full;
  logic [CW_W-1:0]   pend_data;
  logic              pend_load;
  logic              pend_take;

  logic              cw_xfer;
  logic              beat_xfer;
  logic              at_last;
  logic              sending;

  // Ready depends only on registered state; held low while reset is asserted.
  assign cw_ready  = rst_n && !pend_full;
  assign sending   = (state_q == ST_SEND);
  assign cw_xfer   = cw_valid && cw_ready;
  assign beat_xfer = sending && out_ready;
  assign at_last   = (cnt_q == CNT_LAST);

  hamming_cw_hold_reg #(
    .W (CW_W)
  ) u_pend (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pend_load),
    .take_i (pend_take),
    .data_i (cw_data),
    .full_o (pend_full),
    .data_o (pend_data)
  );

  // Next-state: load, shift or hand over to the pending / incoming codeword at frame end.
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    cnt_d     = cnt_q;
    pend_load = 1'b0;
    pend_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cw_xfer) begin
          act_d   = cw_data;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_xfer && !at_last) begin
          act_d = act_q >> LANE_W;
          cnt_d = cnt_q + CNT_W'(1);
          if (cw_xfer) pend_load = 1'b1;
        end else if (beat_xfer && pend_full) begin
          act_d     = pend_data;
          cnt_d     = '0;
          pend_take = 1'b1;
        end else if (beat_xfer && cw_xfer) begin
          act_d = cw_data;
          cnt_d = '0;
        end else if (beat_xfer) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cw_xfer) begin
          pend_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Active shift register, beat counter and state, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
    end
  end

  // Beat outputs are gated by SEND so they read zero while idle or in reset.
  always_comb begin
    out_valid = sending;
    out_data  = sending ? act_q[LANE_W-1:0] : '0;
    out_sof   = sending && (cnt_q == '0);
    out_eof   = sending && at_last;
    out_vbits = !sending ? 8'd0 : (at_last ? VB_LAST : VB_LANE);
    busy      = sending || pend_full;
  end

endmodule
